mult16_cpa_pipe: RTL

- Pipelined final carry-propagate adder for the 16x16 multiplier datapath.
- Sits directly downstream of the column-compressor partition slices. Each slice emits per-column sum/carry bits; the wrapper concatenates them into two 32-bit rows, `in_sum` and `in_carry`.
- This block adds the two rows over two registered stages with valid/ready flow control and delivers the 32-bit product.
- It also keeps a transaction counter for bench and debug visibility.

---
 rtl/mult16_cpa_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult16_cpa_pipe.sv
// Pipelined final carry-propagate adder for the 16x16 multiplier datapath.
// Adds the compressed sum/carry rows over two registered stages with valid/ready flow control.
module mult16_cpa_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPLIT = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_sum_i,
  input  logic [WIDTH-1:0] in_carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_prod_o,
  output logic             out_ovf_o,
  output logic [CNT_W-1:0] tx_count_o
);

  localparam int unsigned HI_W = WIDTH - SPLIT;

  // Stage-1 state: low-half result plus the untouched high halves
  logic              s1_valid_q,    s1_valid_d;
  logic [SPLIT-1:0]  s1_lo_q,       s1_lo_d;
  logic              s1_c1_q,       s1_c1_d;
  logic [HI_W-1:0]   s1_sum_hi_q,   s1_sum_hi_d;
  logic [HI_W-1:0]   s1_carry_hi_q, s1_carry_hi_d;

  // Stage-2 state: the registered product and carry-out
  logic              s2_valid_q,    s2_valid_d;
  logic [WIDTH-1:0]  s2_prod_q,     s2_prod_d;
  logic              s2_ovf_q,      s2_ovf_d;

  logic [CNT_W-1:0]  tx_count_q,    tx_count_d;

  logic              s2_free;
  logic              s1_move;
  logic              in_hs;
  logic              out_hs;
  logic [SPLIT:0]    lo_sum;
  logic [HI_W:0]     hi_sum;

  // Flow control; in_ready depends only on state and out_ready
  always_comb begin
    s2_free    = !s2_valid_q || out_ready_i;
    s1_move    = s1_valid_q && s2_free;
    in_ready_o = !s1_valid_q || s2_free;
    in_hs      = in_valid_i && in_ready_o;
    out_hs     = s2_valid_q && out_ready_i;
  end

  // Split adders: c1 is the only path from the low half into the high half
  always_comb begin
    lo_sum = (SPLIT+1)'(in_sum_i[SPLIT-1:0]) + (SPLIT+1)'(in_carry_i[SPLIT-1:0]);
    hi_sum = (HI_W+1)'(s1_sum_hi_q) + (HI_W+1)'(s1_carry_hi_q) + (HI_W+1)'(s1_c1_q);
  end

  // Stage-1 next state; data only captured on an input handshake
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_lo_d       = s1_lo_q;
    s1_c1_d       = s1_c1_q;
    s1_sum_hi_d   = s1_sum_hi_q;
    s1_carry_hi_d = s1_carry_hi_q;
    if (in_hs) begin
      s1_valid_d    = 1'b1;
      s1_lo_d       = lo_sum[SPLIT-1:0];
      s1_c1_d       = lo_sum[SPLIT];
      s1_sum_hi_d   = in_sum_i[WIDTH-1:SPLIT];
      s1_carry_hi_d = in_carry_i[WIDTH-1:SPLIT];
    end else if (s1_move) begin
      s1_valid_d    = 1'b0;
    end
  end

  // Stage-2 next state; data held while stalled
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_prod_d  = s2_prod_q;
    s2_ovf_d   = s2_ovf_q;
    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_prod_d  = {hi_sum[HI_W-1:0], s1_lo_q};
      s2_ovf_d   = hi_sum[HI_W];
    end else if (out_ready_i) begin
      s2_valid_d = 1'b0;
    end
  end

  // Completed-transaction counter, wraps naturally
  always_comb begin
    tx_count_d = tx_count_q;
    if (out_hs) begin
      tx_count_d = tx_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c1_q       <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s2_valid_q    <= 1'b0;
      s2_prod_q     <= '0;
      s2_ovf_q      <= 1'b0;
      tx_count_q    <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_lo_q       <= s1_lo_d;
      s1_c1_q       <= s1_c1_d;
      s1_sum_hi_q   <= s1_sum_hi_d;
      s1_carry_hi_q <= s1_carry_hi_d;
      s2_valid_q    <= s2_valid_d;
      s2_prod_q     <= s2_prod_d;
      s2_ovf_q      <= s2_ovf_d;
      tx_count_q    <= tx_count_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_prod_o  = s2_prod_q;
  assign out_ovf_o   = s2_ovf_q;
  assign tx_count_o  = tx_count_q;

endmodule
